// File: rtl/tohost_monitor.sv
// Snoops HTIF tohost writes and turns exit/putchar commands into sticky pass/fail status plus a console byte stream.
// Status, console byte and cycle counter are registered, so they are visible one cycle after the accepting edge.
// wr_ready is low whenever a console byte is pending, which stalls every write until the byte drains.
module tohost_monitor #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter logic [63:0]           TIMEOUT_CYCLES = 64'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  putchar_valid,
  input  logic                  putchar_ready,
  output logic [7:0]            putchar_data,
  output logic                  success,
  output logic                  failure,
  output logic [1:0]            reason,
  output logic [31:0]           exit_code,
  output logic [63:0]           cycle_count
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  localparam logic [1:0] REASON_NONE    = 2'd0;
  localparam logic [1:0] REASON_EXIT    = 2'd1;
  localparam logic [1:0] REASON_TIMEOUT = 2'd2;
  localparam logic [1:0] REASON_BADCMD  = 2'd3;

  state_t state;

  // tohost word fields
  logic [7:0]  wr_dev;
  logic [7:0]  wr_cmd;
  logic [47:0] wr_payload;

  assign wr_dev     = wr_data[63:56];
  assign wr_cmd     = wr_data[55:48];
  assign wr_payload = wr_data[47:0];

  // The one-entry console buffer is the only source of backpressure.
  assign wr_ready = !putchar_valid;

  logic wr_fire;
  logic tohost_hit;
  logic is_exit;
  logic exit_pass;
  logic is_putchar;
  logic timeout_hit;

  assign wr_fire    = wr_valid && wr_ready;
  assign tohost_hit = wr_fire && (wr_addr == TOHOST_ADDR);
  assign is_exit    = (wr_dev == 8'd0) && wr_payload[0];
  // Pass/fail is decided on the full 47-bit code even though only 32 bits are reported.
  assign exit_pass  = is_exit && (wr_payload[47:1] == 47'd0);
  assign is_putchar = (wr_dev == 8'd1) && (wr_cmd == 8'd1);
  // A zero limit disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 64'd0) && (cycle_count == TIMEOUT_CYCLES);

  // Run/pass/fail FSM with registered status, console buffer and RUN-cycle counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_RUN;
      success       <= 1'b0;
      failure       <= 1'b0;
      reason        <= REASON_NONE;
      exit_code     <= 32'd0;
      cycle_count   <= 64'd0;
      putchar_valid <= 1'b0;
      putchar_data  <= 8'd0;
    end else begin
      // A pending byte drains in any state; a new byte can only land when the buffer was empty.
      if (putchar_valid && putchar_ready) begin
        putchar_valid <= 1'b0;
      end

      case (state)
        S_RUN: begin
          // An accepted tohost write takes priority over a coincident watchdog expiry.
          // The counter only advances on edges that stay in RUN, so it freezes at the value seen on the terminal edge.
          if (tohost_hit) begin
            if (exit_pass) begin
              state   <= S_PASS;
              success <= 1'b1;
            end else if (is_exit) begin
              state     <= S_FAIL;
              failure   <= 1'b1;
              reason    <= REASON_EXIT;
              exit_code <= wr_payload[32:1];
            end else if (is_putchar) begin
              putchar_valid <= 1'b1;
              putchar_data  <= wr_payload[7:0];
              cycle_count   <= cycle_count + 64'd1;
            end else begin
              state     <= S_FAIL;
              failure   <= 1'b1;
              reason    <= REASON_BADCMD;
              exit_code <= 32'd0;
            end
          end else if (timeout_hit) begin
            state     <= S_FAIL;
            failure   <= 1'b1;
            reason    <= REASON_TIMEOUT;
            exit_code <= 32'd0;
          end else begin
            cycle_count <= cycle_count + 64'd1;
          end
        end
        // PASS and FAIL are absorbing: writes are accepted but have no effect.
        default: begin
        end
      endcase
    end
  end

endmodule
